data_mem_access_unit: RTL

- Data-memory access stage directly downstream of the control unit's EXECUTE/MEMORY_ACCESS states.
- Converts the control unit's mem_rd_en / mem_wr_en strobes into a req/ack transaction on the data-memory bus, handling byte/word lanes and timeouts.
- Returns mem_rd_done / mem_wr_done plus load data for register write-back.
- Nominal latency is 2 clocks with a zero-wait memory.

---
 rtl/data_mem_access_unit_if.sv | 20 ++
 rtl/data_mem_access_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
interface data_mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Turns control-unit read/write strobes into one req/ack data-memory transaction with lanes and timeout.
// Optional: define MEM_ALIGN_CHECK_EN to abort misaligned word accesses without touching the bus.
module data_mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERR_RDATA      = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic        byte_mode,
    output logic        mem_rd_done,
    output logic        mem_wr_done,
    output logic [15:0] rd_data,
    output logic        bus_err,
    data_mem_access_unit_if.master bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, ABORT} state_t;

    state_t             state, state_d;
    logic               rd_en_q, wr_en_q;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic               byte_q, byte_d;
    logic               lsb_q, lsb_d;
    logic               req_d, we_d;
    logic [15:0]        baddr_d, wdata_d, rd_data_d;
    logic [1:0]         be_d;
    logic               rd_done_d, wr_done_d, err_d;
    logic               rd_req, wr_req, misaligned;

    assign rd_req = mem_rd_en & ~rd_en_q;
    assign wr_req = mem_wr_en & ~wr_en_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ~byte_mode & addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        is_wr_d   = is_wr_q;
        byte_d    = byte_q;
        lsb_d     = lsb_q;
        req_d     = bus.bus_req;
        we_d      = bus.bus_we;
        baddr_d   = bus.bus_addr;
        be_d      = bus.bus_be;
        wdata_d   = bus.bus_wdata;
        rd_data_d = rd_data;
        rd_done_d = mem_rd_done;
        wr_done_d = mem_wr_done;
        err_d     = 1'b0;

        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    // Coincident strobes resolve to the write.
                    is_wr_d   = wr_req;
                    byte_d    = byte_mode;
                    lsb_d     = addr[0];
                    rd_done_d = 1'b0;
                    wr_done_d = 1'b0;
                    cnt_d     = '0;
                    if (misaligned) begin
                        state_d = ABORT;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = wr_req;
                        baddr_d = {addr[15:1], 1'b0};
                        be_d    = byte_mode ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                        wdata_d = byte_mode ? {wr_data[7:0], wr_data[7:0]} : wr_data;
                    end
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (is_wr_q) begin
                        wr_done_d = 1'b1;
                    end else begin
                        rd_done_d = 1'b1;
                        if (!byte_q)
                            rd_data_d = bus.bus_rdata;
                        else if (lsb_q)
                            rd_data_d = {8'h00, bus.bus_rdata[15:8]};
                        else
                            rd_data_d = {8'h00, bus.bus_rdata[7:0]};
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ABORT: begin
                // Complete the access with an error so the control unit never stalls.
                err_d   = 1'b1;
                state_d = IDLE;
                if (is_wr_q) begin
                    wr_done_d = 1'b1;
                end else begin
                    rd_done_d = 1'b1;
                    rd_data_d = ERR_RDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            cnt           <= '0;
            is_wr_q       <= 1'b0;
            byte_q        <= 1'b0;
            lsb_q         <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            rd_data       <= '0;
            mem_rd_done   <= 1'b0;
            mem_wr_done   <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            state         <= state_d;
            rd_en_q       <= mem_rd_en;
            wr_en_q       <= mem_wr_en;
            cnt           <= cnt_d;
            is_wr_q       <= is_wr_d;
            byte_q        <= byte_d;
            lsb_q         <= lsb_d;
            bus.bus_req   <= req_d;
            bus.bus_we    <= we_d;
            bus.bus_addr  <= baddr_d;
            bus.bus_be    <= be_d;
            bus.bus_wdata <= wdata_d;
            rd_data       <= rd_data_d;
            mem_rd_done   <= rd_done_d;
            mem_wr_done   <= wr_done_d;
            bus_err       <= err_d;
        end
    end
endmodule
